// File: rtl/mc_arb_pkg.sv
// Shared types and helpers for the per-channel rank arbiter.
package mc_arb_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    RD2WR = 2'd1,
    WRITE = 2'd2,
    WR2RD = 2'd3
  } arb_state_e;

  // Width that holds the sum of n counters, each at most depth.
  function automatic int unsigned cnt_w(input int unsigned depth, input int unsigned n);
    return $clog2(depth * n) + 1;
  endfunction

endpackage

// File: rtl/multi_rank_channel_arbiter_rr_pick.sv
// Round-robin find-first: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid_c,
  output logic [IW-1:0] idx_c
);

  logic [IW-1:0] cand;

  // Scan from the pointer and latch the first hit.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!valid_c && req[cand]) begin
        valid_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/multi_rank_channel_arbiter.sv
// Channel arbiter: owns read/write mode, turnaround, and one-at-a-time
// CMD / CMD+DQ grants to the rank controllers.
// Optional statistics outputs enabled by MULTI_RANK_ARB_STATS_EN.
module multi_rank_channel_arbiter
  import mc_arb_pkg::*;
#(
  parameter int unsigned NUM_RANK           = 2,
  parameter int unsigned READCMDQUEUEDEPTH  = 8,
  parameter int unsigned WRITECMDQUEUEDEPTH = 8,
  parameter int unsigned WR_HIGH_WM         = 6,
  parameter int unsigned WR_LOW_WM          = 2,
  parameter int unsigned tRTW               = 6,
  parameter int unsigned tWTR               = 8,
  parameter int unsigned STARVE_LIMIT       = 64
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_RANK-1:0]                               rank_rd_ready,
  input  logic [NUM_RANK-1:0]                               rank_wr_ready,
  input  logic [NUM_RANK*$clog2(READCMDQUEUEDEPTH)-1:0]     rank_rd_cnt,
  input  logic [NUM_RANK*$clog2(WRITECMDQUEUEDEPTH)-1:0]    rank_wr_cnt,
  input  logic [NUM_RANK-1:0]                               rank_fsm_wait,
  input  logic [NUM_RANK-1:0]                               rank_cmd_ack,
  input  logic [NUM_RANK-1:0]                               rank_rdwr_ack,
  output logic [NUM_RANK-1:0]                               cmd_grant,
  output logic [NUM_RANK-1:0]                               dq_grant,
  output logic                                              write_mode,
  output logic                                              turnaround
`ifdef MULTI_RANK_ARB_STATS_EN
  ,
  output logic [31:0]                                       stat_switches,
  output logic [31:0]                                       stat_starve_switch
`endif
);

  localparam int unsigned WRCW = $clog2(WRITECMDQUEUEDEPTH);
  localparam int unsigned TOTW = cnt_w(WRITECMDQUEUEDEPTH, NUM_RANK);
  localparam int unsigned IW   = (NUM_RANK > 1) ? $clog2(NUM_RANK) : 1;
  localparam int unsigned TMAX = (tWTR > tRTW) ? tWTR : tRTW;
  localparam int unsigned TCW  = $clog2(TMAX + 1);
  localparam int unsigned SCW  = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_q, state_d;
  logic [TCW-1:0]      turn_q, turn_d;
  logic [SCW-1:0]      starve_q, starve_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [NUM_RANK-1:0] cmd_grant_q, cmd_grant_d;
  logic [NUM_RANK-1:0] dq_grant_q, dq_grant_d;
  logic                write_mode_q, write_mode_d;
  logic                turnaround_q, turnaround_d;

  logic [TOTW-1:0]     wr_total;
  logic [NUM_RANK-1:0] mode_ready;
  logic                grant_live, grant_end, can_move;
  logic                starve_hit, go_write, go_read, leave, starve_sw;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;

  // Read counts are not needed for mode decisions.
  logic unused_rd_cnt;
  assign unused_rd_cnt = ^rank_rd_cnt;

  // Total queued writes across the channel.
  always_comb begin
    wr_total = '0;
    for (int unsigned r = 0; r < NUM_RANK; r++) begin
      wr_total = wr_total + TOTW'(rank_wr_cnt[r*WRCW +: WRCW]);
    end
  end

  rr_pick #(.N(NUM_RANK), .IW(IW)) u_pick (
    .req     (mode_ready),
    .ptr     (rr_ptr_q),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  // Mode switch conditions and grant lifetime.
  always_comb begin
    mode_ready = (state_q == WRITE) ? rank_wr_ready : rank_rd_ready;
    grant_live = |(cmd_grant_q | dq_grant_q);
    grant_end  = grant_live & (rank_cmd_ack[gidx_q] | rank_rdwr_ack[gidx_q] | ~mode_ready[gidx_q]);
    can_move   = ~grant_live | grant_end;
    starve_hit = (starve_q == SCW'(STARVE_LIMIT));
    go_write   = (wr_total >= TOTW'(WR_HIGH_WM)) | (~|rank_rd_ready & |rank_wr_ready) | starve_hit;
    go_read    = |rank_rd_ready & ((wr_total <= TOTW'(WR_LOW_WM)) | ~|rank_wr_ready);
  end

  // Next-state: FSM, turnaround/starve counters, grant register.
  always_comb begin
    state_d      = state_q;
    turn_d       = turn_q;
    starve_d     = starve_q;
    rr_ptr_d     = rr_ptr_q;
    gidx_d       = gidx_q;
    cmd_grant_d  = cmd_grant_q;
    dq_grant_d   = dq_grant_q;
    write_mode_d = write_mode_q;
    turnaround_d = turnaround_q;
    leave        = 1'b0;
    starve_sw    = 1'b0;

    case (state_q)
      READ: begin
        if (|rank_wr_ready && !starve_hit) starve_d = starve_q + 1'b1;
        if (go_write && can_move) begin
          state_d      = RD2WR;
          turn_d       = TCW'(tRTW);
          starve_d     = '0;
          write_mode_d = 1'b1;
          turnaround_d = 1'b1;
          leave        = 1'b1;
          starve_sw    = starve_hit;
        end
      end
      WRITE: begin
        if (go_read && can_move) begin
          state_d      = WR2RD;
          turn_d       = TCW'(tWTR);
          write_mode_d = 1'b0;
          turnaround_d = 1'b1;
          leave        = 1'b1;
        end
      end
      RD2WR, WR2RD: begin
        turn_d = turn_q - 1'b1;
        if (turn_q <= TCW'(1)) begin
          state_d      = (state_q == RD2WR) ? WRITE : READ;
          turn_d       = '0;
          turnaround_d = 1'b0;
        end
      end
      default: state_d = READ;
    endcase

    // Hold a live grant until ack or ready drop; pick again only from idle.
    if (grant_live) begin
      if (grant_end) begin
        cmd_grant_d = '0;
        dq_grant_d  = '0;
        rr_ptr_d    = (gidx_q == IW'(NUM_RANK - 1)) ? '0 : gidx_q + 1'b1;
      end
    end else if ((state_q == READ || state_q == WRITE) && !leave && pick_valid) begin
      gidx_d = pick_idx;
      if (rank_fsm_wait[pick_idx]) cmd_grant_d[pick_idx] = 1'b1;
      else                         dq_grant_d[pick_idx]  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= READ;
      turn_q       <= '0;
      starve_q     <= '0;
      rr_ptr_q     <= '0;
      gidx_q       <= '0;
      cmd_grant_q  <= '0;
      dq_grant_q   <= '0;
      write_mode_q <= 1'b0;
      turnaround_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      turn_q       <= turn_d;
      starve_q     <= starve_d;
      rr_ptr_q     <= rr_ptr_d;
      gidx_q       <= gidx_d;
      cmd_grant_q  <= cmd_grant_d;
      dq_grant_q   <= dq_grant_d;
      write_mode_q <= write_mode_d;
      turnaround_q <= turnaround_d;
    end
  end

  assign cmd_grant  = cmd_grant_q;
  assign dq_grant   = dq_grant_q;
  assign write_mode = write_mode_q;
  assign turnaround = turnaround_q;

`ifdef MULTI_RANK_ARB_STATS_EN
  logic [31:0] stat_sw_q, stat_sw_d;
  logic [31:0] stat_starve_q, stat_starve_d;

  // Saturating event counters for turnaround entries and starvation switches.
  always_comb begin
    stat_sw_d     = stat_sw_q;
    stat_starve_d = stat_starve_q;
    if (leave && stat_sw_q != 32'hFFFF_FFFF)         stat_sw_d     = stat_sw_q + 32'd1;
    if (starve_sw && stat_starve_q != 32'hFFFF_FFFF) stat_starve_d = stat_starve_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sw_q     <= '0;
      stat_starve_q <= '0;
    end else begin
      stat_sw_q     <= stat_sw_d;
      stat_starve_q <= stat_starve_d;
    end
  end

  assign stat_switches      = stat_sw_q;
  assign stat_starve_switch = stat_starve_q;
`endif

endmodule

// File: tb/tb_multi_rank_channel_arbiter.sv
// Directed bench for multi_rank_channel_arbiter with four ranks.
module tb_multi_rank_channel_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  rank_rd_ready = '0;
  logic [NR-1:0]  rank_wr_ready = '0;
  logic [NR*CW-1:0] rank_rd_cnt = '0;
  logic [NR*CW-1:0] rank_wr_cnt = '0;
  logic [NR-1:0]  rank_fsm_wait = '0;
  logic [NR-1:0]  rank_cmd_ack = '0;
  logic [NR-1:0]  rank_rdwr_ack = '0;
  logic [NR-1:0]  cmd_grant;
  logic [NR-1:0]  dq_grant;
  logic           write_mode;
  logic           turnaround;
`ifdef MULTI_RANK_ARB_STATS_EN
  logic [31:0]    stat_switches;
  logic [31:0]    stat_starve_switch;
`endif

  int vectors = 0;
  int miscompares = 0;

  multi_rank_channel_arbiter #(.NUM_RANK(NR)) dut (
    .clk           (clk),
    .rst           (rst),
    .rank_rd_ready (rank_rd_ready),
    .rank_wr_ready (rank_wr_ready),
    .rank_rd_cnt   (rank_rd_cnt),
    .rank_wr_cnt   (rank_wr_cnt),
    .rank_fsm_wait (rank_fsm_wait),
    .rank_cmd_ack  (rank_cmd_ack),
    .rank_rdwr_ack (rank_rdwr_ack),
    .cmd_grant     (cmd_grant),
    .dq_grant      (dq_grant),
    .write_mode    (write_mode),
    .turnaround    (turnaround)
`ifdef MULTI_RANK_ARB_STATS_EN
    ,
    .stat_switches      (stat_switches),
    .stat_starve_switch (stat_starve_switch)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rank_rd_ready = '0;
    rank_wr_ready = '0;
    rank_rd_cnt   = '0;
    rank_wr_cnt   = '0;
    rank_fsm_wait = '0;
    rank_cmd_ack  = '0;
    rank_rdwr_ack = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rank_rd_ready = '1; rank_wr_ready = '1; rank_rd_cnt = '1; rank_wr_cnt = '1;
    rank_fsm_wait = '1; rank_cmd_ack = '1; rank_rdwr_ack = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({cmd_grant, dq_grant, write_mode, turnaround} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc%0d: got cmd=%b dq=%b wm=%b ta=%b expected all 0",
                 i, cmd_grant, dq_grant, write_mode, turnaround);
      end
    end
`ifdef MULTI_RANK_ARB_STATS_EN
    vectors++;
    if (stat_switches !== 32'd0 || stat_starve_switch !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_switches, stat_starve_switch);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 3, 0};
    logic [NR-1:0] exp_g;
    do_reset();
    rank_rd_ready = 4'b1011;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_g = NR'(1) << order[i];
      vectors++;
      if (dq_grant !== exp_g || cmd_grant !== '0) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got dq=%b cmd=%b expected dq=%b cmd=0000", i, dq_grant, cmd_grant, exp_g);
      end
      rank_cmd_ack = dq_grant;
      tick();
      rank_cmd_ack = '0;
      vectors++;
      if (dq_grant !== '0 || cmd_grant !== '0) begin
        miscompares++;
        $display("FAIL rr_bubble%0d: got dq=%b cmd=%b expected 0000", i, dq_grant, cmd_grant);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    rank_rd_ready = 4'b0001;
    tick();
    vectors++;
    if (dq_grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_pre: got dq=%b expected 0001", dq_grant);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (dq_grant !== '0 || cmd_grant !== '0) begin
      miscompares++;
      $display("FAIL midrst_drop: got dq=%b cmd=%b expected 0000", dq_grant, cmd_grant);
    end
    rst = 1'b0;
  endtask

  task automatic test_watermarks();
    int n;
    logic bad;
    do_reset();
    rank_rd_ready = 4'b0001;
    rank_wr_ready = 4'b0011;
    rank_wr_cnt   = {3'd0, 3'd0, 3'd3, 3'd3};
    tick();
    vectors++;
    if (turnaround !== 1'b1 || write_mode !== 1'b1) begin
      miscompares++;
      $display("FAIL rd2wr_entry: got ta=%b wm=%b expected 1/1", turnaround, write_mode);
    end
    n = 0; bad = 1'b0;
    while (turnaround === 1'b1 && n < 20) begin
      if (cmd_grant !== '0 || dq_grant !== '0) bad = 1'b1;
      n++;
      tick();
    end
    vectors++;
    if (n != 6 || bad) begin
      miscompares++;
      $display("FAIL rd2wr_len: got %0d cycles grants_seen=%b expected 6 cycles no grants", n, bad);
    end
    vectors++;
    if (write_mode !== 1'b1 || dq_grant !== '0) begin
      miscompares++;
      $display("FAIL write_first: got wm=%b dq=%b expected 1/0000", write_mode, dq_grant);
    end
    tick();
    vectors++;
    if (dq_grant !== 4'b0001 || cmd_grant !== '0) begin
      miscompares++;
      $display("FAIL write_grant: got dq=%b cmd=%b expected 0001/0000", dq_grant, cmd_grant);
    end
    rank_wr_cnt  = {3'd0, 3'd0, 3'd1, 3'd1};
    rank_cmd_ack = 4'b0001;
    tick();
    rank_cmd_ack = '0;
    vectors++;
    if (turnaround !== 1'b1 || write_mode !== 1'b0 || dq_grant !== '0) begin
      miscompares++;
      $display("FAIL wr2rd_entry: got ta=%b wm=%b dq=%b expected 1/0/0000", turnaround, write_mode, dq_grant);
    end
    n = 0;
    while (turnaround === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL wr2rd_len: got %0d cycles expected 8", n);
    end
    tick();
    vectors++;
    if (dq_grant !== 4'b0001 || write_mode !== 1'b0) begin
      miscompares++;
      $display("FAIL read_resume: got dq=%b wm=%b expected 0001/0", dq_grant, write_mode);
    end
`ifdef MULTI_RANK_ARB_STATS_EN
    vectors++;
    if (stat_switches !== 32'd2 || stat_starve_switch !== 32'd0) begin
      miscompares++;
      $display("FAIL wm_stats: got %0d/%0d expected 2/0", stat_switches, stat_starve_switch);
    end
`endif
  endtask

  task automatic test_starvation();
    int n;
    do_reset();
    rank_rd_ready = 4'b0001;
    rank_wr_ready = 4'b0001;
    rank_wr_cnt   = {3'd0, 3'd0, 3'd0, 3'd1};
    rank_cmd_ack  = 4'b1111;
    n = 0;
    while (turnaround !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 65) begin
      miscompares++;
      $display("FAIL starve_edge: got switch at edge %0d expected 65", n);
    end
    vectors++;
    if (write_mode !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_mode: got wm=%b expected 1", write_mode);
    end
`ifdef MULTI_RANK_ARB_STATS_EN
    vectors++;
    if (stat_starve_switch !== 32'd1 || stat_switches !== 32'd1) begin
      miscompares++;
      $display("FAIL starve_stats: got starve=%0d sw=%0d expected 1/1", stat_starve_switch, stat_switches);
    end
`endif
    rank_cmd_ack = '0;
  endtask

  task automatic test_cmd_vs_dq();
    logic [NR-1:0] exp_cmd [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010};
    logic [NR-1:0] exp_dq  [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    rank_rd_ready = 4'b0011;
    rank_fsm_wait = 4'b0010;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cmd_grant !== exp_cmd[i] || dq_grant !== exp_dq[i]) begin
        miscompares++;
        $display("FAIL mixed_pick%0d: got cmd=%b dq=%b expected cmd=%b dq=%b",
                 i, cmd_grant, dq_grant, exp_cmd[i], exp_dq[i]);
      end
      rank_cmd_ack = cmd_grant | dq_grant;
      tick();
      rank_cmd_ack = '0;
      tick();
    end
  endtask

  task automatic test_switch_under_grant();
    do_reset();
    rank_rd_ready = 4'b0100;
    tick();
    vectors++;
    if (dq_grant !== 4'b0100) begin
      miscompares++;
      $display("FAIL hold_start: got dq=%b expected 0100", dq_grant);
    end
    rank_wr_ready = 4'b0001;
    rank_wr_cnt   = {3'd0, 3'd0, 3'd0, 3'd6};
    rank_cmd_ack  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dq_grant !== 4'b0100 || turnaround !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cyc%0d: got dq=%b ta=%b expected 0100/0", i, dq_grant, turnaround);
      end
    end
    rank_cmd_ack  = '0;
    rank_rdwr_ack = 4'b0100;
    tick();
    rank_rdwr_ack = '0;
    vectors++;
    if (dq_grant !== '0 || cmd_grant !== '0 || turnaround !== 1'b1 || write_mode !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: got dq=%b cmd=%b ta=%b wm=%b expected 0000/0000/1/1",
               dq_grant, cmd_grant, turnaround, write_mode);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dq_grant !== '0 || cmd_grant !== '0) begin
        miscompares++;
        $display("FAIL no_grant_ta%0d: got dq=%b cmd=%b expected 0000", i, dq_grant, cmd_grant);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reset_mid_grant();
    test_watermarks();
    test_starvation();
    test_cmd_vs_dq();
    test_switch_under_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
